pciexp_810enc_multi: RTL and testbench

Parametrised 8b/10b encoder that encodes NUM_SYM bytes per clock, for wider PCIe PIPE datapaths.
- Running disparity (RD) chains lane 0 -> lane NUM_SYM-1 within a beat, then carries to the next beat through one register.
- Valid/ready handshake in and out, with one registered output stage.
- Sits between the lane byte-striping logic and the serializer. It replaces the single-symbol, unregistered, always-accepting encoder.

---
 rtl/pciexp_810enc_multi.sv | 246 ++++++++++++++++++++++++
 tb/tb_pciexp_810enc_multi.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pciexp_810enc_multi.sv
// -----------------------------------------------------------------------------
// pciexp_810enc_multi
//
// 8b/10b encoder that encodes NUM_SYM bytes per PCLK250 cycle for wide PIPE
// datapaths. It sits between the lane byte-striping logic and the serializer.
//
// Running disparity chains lane 0 -> lane NUM_SYM-1 inside a beat. The
// disparity after the last lane is kept in one register and seeds the next
// beat. The output has one registered stage with a valid/ready handshake and
// full throughput: a new beat is taken whenever the output register is empty
// or is being drained in the same cycle.
//
// Optional feature (macro PCIEXP_ENC_KERR_EN):
//   defined   - illegal K codes are flagged per lane on KErr_P3 and counted in
//               the saturating KErrCnt (KErrClr clears it, clear wins).
//   undefined - no detection logic; KErr_P3 and KErrCnt read 0 and KErrClr is
//               ignored.
//   Either way an illegal K byte is sent as the data symbol D.x.y.
//
// Ports
//   PCLK250        in   encoder clock
//   Reset_P2       in   asynchronous active-high reset
//   InValid_P2     in   input beat valid
//   InReady_P2     out  encoder can take a beat (~OutValid_P3 | OutReady_P3)
//   DataIn_P2      in   byte n at [8n+7:8n], bit 0 = A
//   KCodeIn_P2     in   bit n set = byte n is a K symbol
//   UseNegDisp_P2  in   start this beat at RD- (sampled on accept only)
//   OutValid_P3    out  output beat valid
//   OutReady_P3    in   downstream takes the output beat
//   DataOut_P3     out  symbol n at [10n+9:10n], bit 0 = a (first on wire)
//   DispOut_P3     out  RD after the last lane of the output beat (1 = RD+)
//   KErr_P3        out  lane n carried an illegal K code
//   KErrCnt        out  saturating count of illegal K symbols
//   KErrClr        in   synchronous clear of KErrCnt
// -----------------------------------------------------------------------------
module pciexp_810enc_multi #(
   parameter int NUM_SYM   = 2,
   parameter int ERR_CNT_W = 8
) (
   input  logic                   PCLK250,
   input  logic                   Reset_P2,
   input  logic                   InValid_P2,
   output logic                   InReady_P2,
   input  logic [8*NUM_SYM-1:0]   DataIn_P2,
   input  logic [NUM_SYM-1:0]     KCodeIn_P2,
   input  logic                   UseNegDisp_P2,
   output logic                   OutValid_P3,
   input  logic                   OutReady_P3,
   output logic [10*NUM_SYM-1:0]  DataOut_P3,
   output logic                   DispOut_P3,
   output logic [NUM_SYM-1:0]     KErr_P3,
   output logic [ERR_CNT_W-1:0]   KErrCnt,
   input  logic                   KErrClr
);

   // 5b/6b codes for RD-, written abcdei (a = MSB of the literal).
   function automatic logic [5:0] six_rdn(input logic [4:0] x);
      logic [5:0] c;
      case (x)
         5'd0:  c = 6'b100111;   5'd1:  c = 6'b011101;
         5'd2:  c = 6'b101101;   5'd3:  c = 6'b110001;
         5'd4:  c = 6'b110101;   5'd5:  c = 6'b101001;
         5'd6:  c = 6'b011001;   5'd7:  c = 6'b111000;
         5'd8:  c = 6'b111001;   5'd9:  c = 6'b100101;
         5'd10: c = 6'b010101;   5'd11: c = 6'b110100;
         5'd12: c = 6'b001101;   5'd13: c = 6'b101100;
         5'd14: c = 6'b011100;   5'd15: c = 6'b010111;
         5'd16: c = 6'b011011;   5'd17: c = 6'b100011;
         5'd18: c = 6'b010011;   5'd19: c = 6'b110010;
         5'd20: c = 6'b001011;   5'd21: c = 6'b101010;
         5'd22: c = 6'b011010;   5'd23: c = 6'b111010;
         5'd24: c = 6'b110011;   5'd25: c = 6'b100110;
         5'd26: c = 6'b010110;   5'd27: c = 6'b110110;
         5'd28: c = 6'b001110;   5'd29: c = 6'b101110;
         5'd30: c = 6'b011110;   5'd31: c = 6'b101011;
         default: c = 6'b000000;
      endcase
      return c;
   endfunction

   // 3b/4b data codes for RD-, written fghj (primary .7).
   function automatic logic [3:0] four_rdn(input logic [2:0] y);
      logic [3:0] c;
      case (y)
         3'd0: c = 4'b1011;   3'd1: c = 4'b1001;
         3'd2: c = 4'b0101;   3'd3: c = 4'b1100;
         3'd4: c = 4'b1101;   3'd5: c = 4'b1010;
         3'd6: c = 4'b0110;   3'd7: c = 4'b1110;
         default: c = 4'b0000;
      endcase
      return c;
   endfunction

   function automatic logic is_bal6(input logic [5:0] c);
      int n;
      n = 0;
      for (int i = 0; i < 6; i++) n += int'(c[i]);
      return (n == 3);
   endfunction

   function automatic logic is_bal4(input logic [3:0] c);
      int n;
      n = 0;
      for (int i = 0; i < 4; i++) n += int'(c[i]);
      return (n == 2);
   endfunction

   // K.28.y and K.23/27/29/30.7 are the only legal control symbols.
   function automatic logic k_legal(input logic [7:0] b);
      return (b[4:0] == 5'd28) ||
             ((b[7:5] == 3'd7) &&
              ((b[4:0] == 5'd23) || (b[4:0] == 5'd27) ||
               (b[4:0] == 5'd29) || (b[4:0] == 5'd30)));
   endfunction

   // Encodes one byte at running disparity rd; returns {rd_after, symbol}.
   // Symbol bit 0 is 'a'. RD+ codes are the bitwise complement of RD- codes
   // for unbalanced sub-blocks and for the two balanced-but-alternating
   // codes D.7 (111000/000111) and .3 (1100/0011).
   function automatic logic [10:0] enc_sym(input logic [7:0] b,
                                           input logic       k,
                                           input logic       rd);
      logic [4:0] x;
      logic [2:0] y;
      logic       kl;
      logic       unb6;
      logic       unb4;
      logic       rd_mid;
      logic       alt7;
      logic [5:0] six;
      logic [3:0] four;
      logic [9:0] seq;
      logic [9:0] code;
      x    = b[4:0];
      y    = b[7:5];
      kl   = k & k_legal(b);
      six  = (kl && (x == 5'd28)) ? 6'b001111 : six_rdn(x);
      unb6 = ~is_bal6(six);
      if (rd && (unb6 || (x == 5'd7))) six = ~six;
      rd_mid = rd ^ unb6;
      // A7 avoids a run of five equal bits across the sub-block boundary;
      // every legal K.x.7 uses it as well.
      alt7 = (y == 3'd7) &&
             (kl ||
              (!rd_mid && ((x == 5'd17) || (x == 5'd18) || (x == 5'd20))) ||
              ( rd_mid && ((x == 5'd11) || (x == 5'd13) || (x == 5'd14))));
      four = alt7 ? 4'b0111 : four_rdn(y);
      unb4 = ~is_bal4(four);
      // K.x.1/.2/.5/.6 use the inverted balanced code after an RD- sub-block
      // so the comma pattern survives.
      if (kl && ((y == 3'd1) || (y == 3'd2) || (y == 3'd5) || (y == 3'd6))) begin
         if (!rd_mid) four = ~four;
      end else if (rd_mid && (unb4 || (y == 3'd3))) begin
         four = ~four;
      end
      seq = {six, four};
      for (int i = 0; i < 10; i++) code[i] = seq[9-i];
      return {rd_mid ^ unb4, code};
   endfunction

   logic                   vld_p3;
   logic                   rd_p3;
   logic [10*NUM_SYM-1:0]  data_p3;
   logic                   accept_p2;
   logic                   rd_nxt_p2;
   logic [10*NUM_SYM-1:0]  enc_p2;

   assign InReady_P2  = ~vld_p3 | OutReady_P3;
   assign accept_p2   = InValid_P2 & InReady_P2;
   assign OutValid_P3 = vld_p3;
   assign DataOut_P3  = data_p3;
   // The stored RD and the reported disparity are the same quantity.
   assign DispOut_P3  = rd_p3;

   // ---- P2: disparity chain across the lanes of the incoming beat ----
   always_comb begin
      logic        rd_chain;
      logic [10:0] r;
      r        = '0;
      enc_p2   = '0;
      rd_chain = UseNegDisp_P2 ? 1'b0 : rd_p3;
      for (int n = 0; n < NUM_SYM; n++) begin
         r                  = enc_sym(DataIn_P2[8*n +: 8], KCodeIn_P2[n], rd_chain);
         enc_p2[10*n +: 10] = r[9:0];
         rd_chain           = r[10];
      end
      rd_nxt_p2 = rd_chain;
   end

   // ---- P3: output register; RD only moves when a beat is accepted ----
   always_ff @(posedge PCLK250 or posedge Reset_P2) begin
      if (Reset_P2) begin
         vld_p3  <= 1'b0;
         data_p3 <= '0;
         rd_p3   <= 1'b0;
      end else if (accept_p2) begin
         vld_p3  <= 1'b1;
         data_p3 <= enc_p2;
         rd_p3   <= rd_nxt_p2;
      end else if (OutReady_P3) begin
         vld_p3  <= 1'b0;
      end
   end

`ifdef PCIEXP_ENC_KERR_EN
   function automatic logic [ERR_CNT_W-1:0] sat_add(input logic [ERR_CNT_W-1:0] cnt,
                                                    input logic [NUM_SYM-1:0]   inc);
      logic [ERR_CNT_W:0] s;
      s = {1'b0, cnt};
      for (int n = 0; n < NUM_SYM; n++) s = s + {{ERR_CNT_W{1'b0}}, inc[n]};
      return s[ERR_CNT_W] ? {ERR_CNT_W{1'b1}} : s[ERR_CNT_W-1:0];
   endfunction

   logic [NUM_SYM-1:0]    kerr_nxt_p2;
   logic [NUM_SYM-1:0]    kerr_p3;
   logic [ERR_CNT_W-1:0]  err_cnt;

   // ---- P2: illegal-K flags per lane ----
   always_comb begin
      kerr_nxt_p2 = '0;
      for (int n = 0; n < NUM_SYM; n++)
         kerr_nxt_p2[n] = KCodeIn_P2[n] & ~k_legal(DataIn_P2[8*n +: 8]);
   end

   // ---- P3: flags registered with the symbols, counter ----
   always_ff @(posedge PCLK250 or posedge Reset_P2) begin
      if (Reset_P2)       kerr_p3 <= '0;
      else if (accept_p2) kerr_p3 <= kerr_nxt_p2;
   end

   always_ff @(posedge PCLK250 or posedge Reset_P2) begin
      if (Reset_P2)       err_cnt <= '0;
      else if (KErrClr)   err_cnt <= '0;
      else if (accept_p2) err_cnt <= sat_add(err_cnt, kerr_nxt_p2);
   end

   assign KErr_P3 = kerr_p3;
   assign KErrCnt = err_cnt;
`else
   logic unused_kerr_clr;
   assign unused_kerr_clr = KErrClr;
   assign KErr_P3 = '0;
   assign KErrCnt = '0;
`endif

endmodule

// File: tb/tb_pciexp_810enc_multi.sv
module tb_pciexp_810enc_multi;

`ifdef PCIEXP_ENC_KERR_EN
   localparam bit KEN = 1'b1;
`else
   localparam bit KEN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // single-lane instance
   logic        a_iv = 0, a_ir, a_neg = 0, a_ov, a_or = 1, a_disp, a_clr = 0;
   logic [7:0]  a_din = 0;
   logic [0:0]  a_kin = 0, a_kerr;
   logic [9:0]  a_dout;
   logic [7:0]  a_cnt;

   // two-lane instance
   logic        b_iv = 0, b_ir, b_neg = 0, b_ov, b_or = 1, b_disp, b_clr = 0;
   logic [15:0] b_din = 0;
   logic [1:0]  b_kin = 0, b_kerr;
   logic [19:0] b_dout;
   logic [7:0]  b_cnt;

   pciexp_810enc_multi #(.NUM_SYM(1), .ERR_CNT_W(8)) dut1 (
      .PCLK250(clk), .Reset_P2(rst), .InValid_P2(a_iv), .InReady_P2(a_ir),
      .DataIn_P2(a_din), .KCodeIn_P2(a_kin), .UseNegDisp_P2(a_neg),
      .OutValid_P3(a_ov), .OutReady_P3(a_or), .DataOut_P3(a_dout),
      .DispOut_P3(a_disp), .KErr_P3(a_kerr), .KErrCnt(a_cnt), .KErrClr(a_clr));

   pciexp_810enc_multi #(.NUM_SYM(2), .ERR_CNT_W(8)) dut2 (
      .PCLK250(clk), .Reset_P2(rst), .InValid_P2(b_iv), .InReady_P2(b_ir),
      .DataIn_P2(b_din), .KCodeIn_P2(b_kin), .UseNegDisp_P2(b_neg),
      .OutValid_P3(b_ov), .OutReady_P3(b_or), .DataOut_P3(b_dout),
      .DispOut_P3(b_disp), .KErr_P3(b_kerr), .KErrCnt(b_cnt), .KErrClr(b_clr));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Reference code tables, written abcdei / fghj (a = MSB of literal).
   logic [5:0] six_neg [32] = '{
      6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
      6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
      6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
      6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
   logic [5:0] six_pos [32] = '{
      6'b011000, 6'b100010, 6'b010010, 6'b110001, 6'b001010, 6'b101001, 6'b011001, 6'b000111,
      6'b000110, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b101000,
      6'b100100, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b000101,
      6'b001100, 6'b100110, 6'b010110, 6'b001001, 6'b001110, 6'b010001, 6'b100001, 6'b010100};
   logic [3:0] four_neg [8] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
   logic [3:0] four_pos [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b0001};
   // Full K symbols at RD- (K28.0..7, K23.7, K27.7, K29.7, K30.7); RD+ is the complement.
   logic [9:0] ktab [12] = '{
      10'b001111_0100, 10'b001111_1001, 10'b001111_0101, 10'b001111_0011,
      10'b001111_0010, 10'b001111_1010, 10'b001111_0110, 10'b001111_1000,
      10'b111010_1000, 10'b110110_1000, 10'b101110_1000, 10'b011110_1000};
   logic [7:0] kbytes [12] = '{8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC, 8'hDC, 8'hFC,
                               8'hF7, 8'hFB, 8'hFD, 8'hFE};

   function automatic int ones(input logic [9:0] v);
      int n = 0;
      for (int i = 0; i < 10; i++) n += int'(v[i]);
      return n;
   endfunction

   function automatic bit ref_legal(input logic [7:0] b, input logic k);
      int x = int'(b[4:0]);
      int y = int'(b[7:5]);
      return k && (x == 28 || (y == 7 && (x == 23 || x == 27 || x == 29 || x == 30)));
   endfunction

   task automatic ref_enc(input logic [7:0] b, input logic k, input logic rd,
                          output logic [9:0] code, output logic rd_o);
      int x = int'(b[4:0]);
      int y = int'(b[7:5]);
      int idx, o6, o;
      logic [9:0] seq;
      logic [5:0] s6;
      logic [3:0] s4;
      logic rdm;
      bit alt;
      if (ref_legal(b, k)) begin
         idx = (x == 28) ? y : (x == 23) ? 8 : (x == 27) ? 9 : (x == 29) ? 10 : 11;
         seq = rd ? ~ktab[idx] : ktab[idx];
      end else begin
         s6  = rd ? six_pos[x] : six_neg[x];
         o6  = ones({4'b0000, s6});
         rdm = (o6 > 3) ? 1'b1 : (o6 < 3) ? 1'b0 : rd;
         alt = (y == 7) && ((!rdm && (x == 17 || x == 18 || x == 20)) ||
                            ( rdm && (x == 11 || x == 13 || x == 14)));
         s4  = alt ? (rdm ? 4'b1000 : 4'b0111) : (rdm ? four_pos[y] : four_neg[y]);
         seq = {s6, s4};
      end
      o = ones(seq);
      rd_o = (o > 5) ? 1'b1 : (o < 5) ? 1'b0 : rd;
      for (int i = 0; i < 10; i++) code[i] = seq[9-i];
   endtask

   // Two-lane transaction model
   logic        m_ov = 0, m_rd = 0;
   logic [19:0] m_data = 0;
   logic [1:0]  m_kerr = 0;
   int          m_cnt = 0;

   task automatic b_cycle(input logic iv, input logic [15:0] d, input logic [1:0] k,
                          input logic neg, input logic ordy, input logic clr);
      logic exp_rdy, acc, rd;
      logic [9:0] code;
      int nerr;
      b_iv = iv; b_din = d; b_kin = k; b_neg = neg; b_or = ordy; b_clr = clr;
      #1;
      exp_rdy = !m_ov || ordy;
      chk("b_in_ready", b_ir, exp_rdy);
      acc = iv && exp_rdy;
      @(posedge clk);
      if (acc) begin
         rd = neg ? 1'b0 : m_rd;
         nerr = 0;
         for (int l = 0; l < 2; l++) begin
            ref_enc(d[8*l +: 8], k[l], rd, code, rd);
            m_data[10*l +: 10] = code;
            m_kerr[l] = k[l] && !ref_legal(d[8*l +: 8], k[l]);
            nerr += int'(m_kerr[l]);
         end
         m_rd = rd;
         m_ov = 1'b1;
         if (!clr) m_cnt = (m_cnt + nerr > 255) ? 255 : m_cnt + nerr;
      end else if (ordy) begin
         m_ov = 1'b0;
      end
      if (clr) m_cnt = 0;
      #1;
      chk("b_out_valid", b_ov, m_ov);
      chk("b_data_out", b_dout, m_data);
      chk("b_disp_out", b_disp, m_rd);
      chk("b_kerr", b_kerr, KEN ? m_kerr : 2'b00);
      chk("b_kerr_cnt", b_cnt, KEN ? m_cnt : 0);
      @(negedge clk);
   endtask

   typedef struct {
      logic [7:0] din;
      logic       k;
      logic       neg;
      logic [9:0] code;
      logic       disp;
      logic       kerr;
   } vec_t;

   vec_t vt [12];

   initial begin
      logic [15:0] rd_d;
      logic [1:0]  rd_k;
      vt[0]  = '{8'h00, 1'b0, 1'b0, 10'h0B9, 1'b0, 1'b0};  // D.0.0 RD-
      vt[1]  = '{8'hBC, 1'b1, 1'b0, 10'h17C, 1'b1, 1'b0};  // K28.5 RD-
      vt[2]  = '{8'hBC, 1'b1, 1'b0, 10'h283, 1'b0, 1'b0};  // K28.5 RD+
      vt[3]  = '{8'hBC, 1'b1, 1'b0, 10'h17C, 1'b1, 1'b0};
      vt[4]  = '{8'h00, 1'b0, 1'b0, 10'h346, 1'b1, 1'b0};  // D.0.0 RD+
      vt[5]  = '{8'hBC, 1'b1, 1'b1, 10'h17C, 1'b1, 1'b0};  // forced RD-
      vt[6]  = '{8'hB5, 1'b0, 1'b1, 10'h155, 1'b0, 1'b0};  // D.21.5 forced RD-
      vt[7]  = '{8'hB5, 1'b0, 1'b0, 10'h155, 1'b0, 1'b0};
      vt[8]  = '{8'hF1, 1'b0, 1'b0, 10'h3B1, 1'b1, 1'b0};  // D.17.A7 RD-
      vt[9]  = '{8'hEB, 1'b0, 1'b0, 10'h04B, 1'b0, 1'b0};  // D.11.A7 RD+
      vt[10] = '{8'h00, 1'b1, 1'b0, 10'h0B9, 1'b0, 1'b1};  // illegal K -> D.0.0
      vt[11] = '{8'hFB, 1'b1, 1'b0, 10'h05B, 1'b0, 1'b0};  // K27.7 RD-

      // reset state
      #2;
      chk("a_rst_valid", a_ov, 0);   chk("a_rst_data", a_dout, 0);
      chk("a_rst_disp", a_disp, 0);  chk("a_rst_kerr", a_kerr, 0);
      chk("a_rst_cnt", a_cnt, 0);
      chk("b_rst_valid", b_ov, 0);   chk("b_rst_data", b_dout, 0);
      chk("b_rst_disp", b_disp, 0);  chk("b_rst_kerr", b_kerr, 0);
      chk("b_rst_cnt", b_cnt, 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("a_ready_after_rst", a_ir, 1);
      chk("b_ready_after_rst", b_ir, 1);

      // single-lane vector table, back to back
      for (int i = 0; i < 12; i++) begin
         a_iv = 1'b1; a_din = vt[i].din; a_kin[0] = vt[i].k; a_neg = vt[i].neg; a_or = 1'b1;
         #1;
         chk("a_in_ready", a_ir, 1);
         @(posedge clk);
         #1;
         chk("a_valid", a_ov, 1);
         chk("a_code", a_dout, vt[i].code);
         chk("a_disp", a_disp, vt[i].disp);
         chk("a_kerr", a_kerr, KEN ? vt[i].kerr : 1'b0);
         @(negedge clk);
      end
      a_iv = 1'b0;
      @(posedge clk);
      #1;
      chk("a_idle_valid", a_ov, 0);
      chk("a_cnt", a_cnt, KEN ? 1 : 0);
      @(negedge clk);

      // two K28.5 lanes in one beat
      b_cycle(1, 16'hBCBC, 2'b11, 0, 1, 0);
      chk("b_k285_lane0", b_dout[9:0], 10'h17C);
      chk("b_k285_lane1", b_dout[19:10], 10'h283);
      chk("b_k285_disp", b_disp, 0);

      // stall for three cycles, then release
      b_cycle(1, 16'h00BC, 2'b01, 0, 1, 0);
      for (int i = 0; i < 3; i++) b_cycle(1, 16'h1234, 2'b00, 0, 0, 0);
      chk("b_stall_data", b_dout, {10'h346, 10'h17C});
      chk("b_stall_disp", b_disp, 1);
      b_cycle(1, 16'h0000, 2'b00, 0, 1, 0);
      chk("b_release_data", b_dout, {10'h346, 10'h346});

      // illegal K on both lanes, saturation, clear priority
      b_cycle(1, 16'h0000, 2'b11, 0, 1, 0);
      chk("b_kerr_both", b_kerr, KEN ? 2'b11 : 2'b00);
      for (int i = 0; i < 130; i++) b_cycle(1, 16'h0000, 2'b11, 0, 1, 0);
      chk("b_cnt_sat", b_cnt, KEN ? 8'hFF : 8'h00);
      b_cycle(1, 16'h0000, 2'b11, 0, 1, 1);
      chk("b_cnt_clr", b_cnt, 0);
      b_cycle(0, 16'h0000, 2'b00, 0, 1, 0);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         for (int l = 0; l < 2; l++) begin
            if ($urandom_range(0, 3) == 0) begin
               rd_d[8*l +: 8] = kbytes[$urandom_range(0, 11)];
               rd_k[l] = 1'b1;
            end else begin
               rd_d[8*l +: 8] = 8'($urandom);
               rd_k[l] = ($urandom_range(0, 7) == 0);
            end
         end
         b_cycle($urandom_range(0, 3) != 0, rd_d, rd_k, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);
      end

      // reset while a beat is held, first beat afterwards starts at RD-
      b_cycle(1, 16'h00BC, 2'b01, 0, 0, 0);
      b_cycle(0, 16'h0000, 2'b00, 0, 0, 0);
      #2;
      rst = 1'b1;
      #1;
      chk("b_midrst_valid", b_ov, 0);
      chk("b_midrst_data", b_dout, 0);
      chk("b_midrst_disp", b_disp, 0);
      chk("b_midrst_cnt", b_cnt, 0);
      m_ov = 0; m_rd = 0; m_data = 0; m_kerr = 0; m_cnt = 0;
      @(negedge clk);
      rst = 1'b0;
      b_cycle(1, 16'h0000, 2'b00, 0, 1, 0);
      chk("b_post_rst_data", b_dout, {10'h0B9, 10'h0B9});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
